// File: rtl/io_rx_fifo_mark.sv
// RX-direction marking FIFO: buffers peripheral words tagged with SOF/EOF, drains them through a
// req/gnt handshake, emits marker pulses on grant and measures completed frame lengths.
module io_rx_fifo_mark #(
    parameter int unsigned DATA_WIDTH       = 32,
    parameter int unsigned BUFFER_DEPTH     = 4,
    parameter int unsigned LOG_BUFFER_DEPTH = $clog2(BUFFER_DEPTH)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        clr_i,
    input  logic                        valid_i,
    input  logic [DATA_WIDTH-1:0]       data_i,
    input  logic                        sof_i,
    input  logic                        eof_i,
    output logic                        ready_o,
    output logic                        req_o,
    input  logic                        gnt_i,
    output logic [DATA_WIDTH-1:0]       data_o,
    output logic                        sof_o,
    output logic                        eof_o,
    output logic                        sof_evt_o,
    output logic                        eof_evt_o,
    output logic                        frame_done_o,
    output logic [15:0]                 frame_len_o,
    output logic [LOG_BUFFER_DEPTH:0]   elements_o
);

    localparam int unsigned EntryW = DATA_WIDTH + 2;
    localparam logic [LOG_BUFFER_DEPTH:0]   DepthCnt = (LOG_BUFFER_DEPTH + 1)'(BUFFER_DEPTH);
    localparam logic [LOG_BUFFER_DEPTH-1:0] LastPtr  = LOG_BUFFER_DEPTH'(BUFFER_DEPTH - 1);

    logic [EntryW-1:0]           storage_q [BUFFER_DEPTH];
    logic [EntryW-1:0]           storage_d [BUFFER_DEPTH];
    logic [LOG_BUFFER_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [LOG_BUFFER_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [LOG_BUFFER_DEPTH:0]   count_q, count_d;
    logic [15:0]                 r_cnt_q, r_cnt_d;
    logic [15:0]                 frame_len_q, frame_len_d;
    logic                        frame_done_q, frame_done_d;

    logic        push;
    logic        pop;
    logic [15:0] cnt_inc;

    assign ready_o = (count_q != DepthCnt);
    assign req_o   = (count_q != '0);

    assign data_o = storage_q[rd_ptr_q][DATA_WIDTH-1:0];
    assign sof_o  = storage_q[rd_ptr_q][DATA_WIDTH];
    assign eof_o  = storage_q[rd_ptr_q][DATA_WIDTH+1];

    // A flush cycle discards both sides of the handshake.
    assign push = valid_i & ready_o & ~clr_i;
    assign pop  = req_o & gnt_i & ~clr_i;

    assign sof_evt_o    = pop & sof_o;
    assign eof_evt_o    = pop & eof_o;
    assign frame_done_o = frame_done_q;
    assign frame_len_o  = frame_len_q;
    assign elements_o   = count_q;

    assign cnt_inc = (r_cnt_q == 16'hFFFF) ? 16'hFFFF : r_cnt_q + 16'd1;

    always_comb begin
        storage_d    = storage_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        r_cnt_d      = r_cnt_q;
        frame_len_d  = frame_len_q;
        frame_done_d = 1'b0;

        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            r_cnt_d  = '0;
        end else begin
            if (push) begin
                storage_d[wr_ptr_q] = {eof_i, sof_i, data_i};
                wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
                if (eof_o) begin
                    frame_len_d  = sof_o ? 16'd1 : cnt_inc;
                    frame_done_d = 1'b1;
                    r_cnt_d      = '0;
                end else if (sof_o) begin
                    r_cnt_d = 16'd1;
                end else begin
                    r_cnt_d = cnt_inc;
                end
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(BUFFER_DEPTH); i++) begin
                storage_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            r_cnt_q      <= '0;
            frame_len_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            storage_q    <= storage_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            r_cnt_q      <= r_cnt_d;
            frame_len_q  <= frame_len_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_io_rx_fifo_mark.sv
// Directed, table-driven bench for io_rx_fifo_mark: per-cycle vectors plus a saturating long frame.
module tb_io_rx_fifo_mark;

    localparam int unsigned DW = 32;
    localparam int unsigned NV = 27;

    logic          clk = 1'b0;
    logic          rst_i, clr_i, valid_i, sof_i, eof_i, gnt_i;
    logic [DW-1:0] data_i;
    logic          ready_o, req_o, sof_o, eof_o, sof_evt_o, eof_evt_o, frame_done_o;
    logic [DW-1:0] data_o;
    logic [15:0]   frame_len_o;
    logic [2:0]    elements_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    io_rx_fifo_mark #(
        .DATA_WIDTH(DW),
        .BUFFER_DEPTH(4)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_i),
        .clr_i(clr_i),
        .valid_i(valid_i),
        .data_i(data_i),
        .sof_i(sof_i),
        .eof_i(eof_i),
        .ready_o(ready_o),
        .req_o(req_o),
        .gnt_i(gnt_i),
        .data_o(data_o),
        .sof_o(sof_o),
        .eof_o(eof_o),
        .sof_evt_o(sof_evt_o),
        .eof_evt_o(eof_evt_o),
        .frame_done_o(frame_done_o),
        .frame_len_o(frame_len_o),
        .elements_o(elements_o)
    );

    typedef struct {
        logic          valid;
        logic [DW-1:0] data;
        logic          sof;
        logic          eof;
        logic          gnt;
        logic          clr;
        logic          e_ready;
        logic          e_req;
        logic [DW-1:0] e_data;
        logic          e_sof;
        logic          e_eof;
        logic          e_sevt;
        logic          e_eevt;
        logic          e_done;
        logic [15:0]   e_len;
        logic [2:0]    e_el;
    } vec_t;

    vec_t vecs [NV];

    function automatic vec_t mk(logic v, logic [DW-1:0] d, logic s, logic e, logic g, logic c,
                                logic rdy, logic rq, logic [DW-1:0] ed, logic es, logic ee,
                                logic sev, logic eev, logic dn, logic [15:0] ln, logic [2:0] el);
        vec_t r;
        r.valid = v;  r.data = d;  r.sof = s;  r.eof = e;  r.gnt = g;  r.clr = c;
        r.e_ready = rdy;  r.e_req = rq;  r.e_data = ed;  r.e_sof = es;  r.e_eof = ee;
        r.e_sevt = sev;  r.e_eevt = eev;  r.e_done = dn;  r.e_len = ln;  r.e_el = el;
        return r;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (vec %0d): got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic check_vec(input int i, input vec_t v);
        chk("ready_o", i, 32'(ready_o), 32'(v.e_ready));
        chk("req_o", i, 32'(req_o), 32'(v.e_req));
        if (v.e_req) begin
            chk("data_o", i, data_o, v.e_data);
            chk("sof_o", i, 32'(sof_o), 32'(v.e_sof));
            chk("eof_o", i, 32'(eof_o), 32'(v.e_eof));
        end
        chk("sof_evt_o", i, 32'(sof_evt_o), 32'(v.e_sevt));
        chk("eof_evt_o", i, 32'(eof_evt_o), 32'(v.e_eevt));
        chk("frame_done_o", i, 32'(frame_done_o), 32'(v.e_done));
        chk("frame_len_o", i, 32'(frame_len_o), 32'(v.e_len));
        chk("elements_o", i, 32'(elements_o), 32'(v.e_el));
    endtask

    localparam logic [DW-1:0] A  = 32'hA000_000A, B  = 32'hB000_000B, C  = 32'hC000_000C;
    localparam logic [DW-1:0] D0 = 32'hD000_0000, D1 = 32'hD000_0001, D2 = 32'hD000_0002;
    localparam logic [DW-1:0] D3 = 32'hD000_0003, D4 = 32'hD000_0004, E  = 32'hE000_000E;
    localparam logic [DW-1:0] F0 = 32'hF000_0000, F1 = 32'hF000_0001, G  = 32'h9999_9999;
    localparam logic [DW-1:0] H0 = 32'h1234_0000, H1 = 32'h1234_0001;

    initial begin
        // Frame A,B,C streamed with gnt held high
        vecs[0]  = mk(1, A, 1, 0, 1, 0,  1, 0, 0,  0, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(1, B, 0, 0, 1, 0,  1, 1, A,  1, 0, 1, 0, 0, 0, 1);
        vecs[2]  = mk(1, C, 0, 1, 1, 0,  1, 1, B,  0, 0, 0, 0, 0, 0, 1);
        vecs[3]  = mk(0, 0, 0, 0, 1, 0,  1, 1, C,  0, 1, 0, 1, 0, 0, 1);
        vecs[4]  = mk(0, 0, 0, 0, 1, 0,  1, 0, 0,  0, 0, 0, 0, 1, 3, 0);
        // Fill to full, fifth word held, full push+pop, wrap order
        vecs[5]  = mk(1, D0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 3, 0);
        vecs[6]  = mk(1, D1, 0, 0, 0, 0, 1, 1, D0, 0, 0, 0, 0, 0, 3, 1);
        vecs[7]  = mk(1, D2, 0, 0, 0, 0, 1, 1, D0, 0, 0, 0, 0, 0, 3, 2);
        vecs[8]  = mk(1, D3, 0, 0, 0, 0, 1, 1, D0, 0, 0, 0, 0, 0, 3, 3);
        vecs[9]  = mk(1, D4, 0, 0, 0, 0, 0, 1, D0, 0, 0, 0, 0, 0, 3, 4);
        vecs[10] = mk(1, D4, 0, 0, 1, 0, 0, 1, D0, 0, 0, 0, 0, 0, 3, 4);
        vecs[11] = mk(1, D4, 0, 0, 0, 0, 1, 1, D1, 0, 0, 0, 0, 0, 3, 3);
        vecs[12] = mk(0, 0,  0, 0, 1, 0, 0, 1, D1, 0, 0, 0, 0, 0, 3, 4);
        vecs[13] = mk(0, 0,  0, 0, 1, 0, 1, 1, D2, 0, 0, 0, 0, 0, 3, 3);
        vecs[14] = mk(0, 0,  0, 0, 1, 0, 1, 1, D3, 0, 0, 0, 0, 0, 3, 2);
        vecs[15] = mk(0, 0,  0, 0, 1, 0, 1, 1, D4, 0, 0, 0, 0, 0, 3, 1);
        // Single-word frame
        vecs[16] = mk(1, E, 1, 1, 1, 0,  1, 0, 0,  0, 0, 0, 0, 0, 3, 0);
        vecs[17] = mk(0, 0, 0, 0, 1, 0,  1, 1, E,  1, 1, 1, 1, 0, 3, 1);
        vecs[18] = mk(0, 0, 0, 0, 0, 0,  1, 0, 0,  0, 0, 0, 0, 1, 1, 0);
        // Partial frame flushed while granted, then a 2-word frame
        vecs[19] = mk(1, F0, 1, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 1, 0);
        vecs[20] = mk(1, F1, 0, 0, 0, 0, 1, 1, F0, 1, 0, 0, 0, 0, 1, 1);
        vecs[21] = mk(1, G,  1, 1, 1, 1, 1, 1, F0, 1, 0, 0, 0, 0, 1, 2);
        vecs[22] = mk(0, 0,  0, 0, 1, 0, 1, 0, 0,  0, 0, 0, 0, 0, 1, 0);
        vecs[23] = mk(1, H0, 1, 0, 1, 0, 1, 0, 0,  0, 0, 0, 0, 0, 1, 0);
        vecs[24] = mk(1, H1, 0, 1, 1, 0, 1, 1, H0, 1, 0, 1, 0, 0, 1, 1);
        vecs[25] = mk(0, 0,  0, 0, 1, 0, 1, 1, H1, 0, 1, 0, 1, 0, 1, 1);
        vecs[26] = mk(0, 0,  0, 0, 1, 0, 1, 0, 0,  0, 0, 0, 0, 1, 2, 0);

        rst_i = 1'b1;  clr_i = 1'b0;  valid_i = 1'b0;  data_i = '0;
        sof_i = 1'b0;  eof_i = 1'b0;  gnt_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        check_vec(-1, mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("reset data_o", -1, data_o, 32'h0);
        chk("reset sof_o", -1, 32'(sof_o), 32'h0);
        chk("reset eof_o", -1, 32'(eof_o), 32'h0);

        for (int i = 0; i < int'(NV); i++) begin
            @(posedge clk);
            #1;
            valid_i = vecs[i].valid;  data_i = vecs[i].data;  sof_i = vecs[i].sof;
            eof_i = vecs[i].eof;  gnt_i = vecs[i].gnt;  clr_i = vecs[i].clr;
            @(negedge clk);
            check_vec(i, vecs[i]);
        end

        // 70000-word frame streamed at one word per cycle; length must saturate
        for (int i = 0; i < 70000; i++) begin
            @(posedge clk);
            #1;
            valid_i = 1'b1;  gnt_i = 1'b1;  clr_i = 1'b0;  data_i = DW'(i);
            sof_i = (i == 0);  eof_i = (i == 69999);
        end
        @(posedge clk);
        #1 valid_i = 1'b0;  sof_i = 1'b0;  eof_i = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (frame_done_o) break;
        end
        chk("long frame_done_o", 99, 32'(frame_done_o), 32'h1);
        chk("long frame_len_o", 99, 32'(frame_len_o), 32'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
